ula_sequenciador: RTL and testbench

Command sequencer in front of the 8-bit ULA. It accepts one operation (A, B, Sel) per valid/ready handshake and registers the operands to drive the ULA. It pulses ula_start, waits for ula_pronto (multi-cycle multiply), bounds the wait with a timeout, then captures the result, remainder and derived flags into a result register held under a valid/ready handshake. It sits between the control FSM/register file and the ULA.

---
 rtl/ula_sequenciador.sv | 228 ++++++++++++++++++++++
 tb/tb_ula_sequenciador.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_sequenciador.sv
// rtl/ula_sequenciador.sv - command sequencer driving the 8-bit ULA with result/flag capture
//
// Accepts one operation (A, B, Sel) per cmd handshake, registers it onto the
// ULA operand lines, pulses ula_start, waits for ula_pronto with a bounded
// wait, then captures result, remainder and flags into a result register
// presented under a res_valid/res_ready handshake.
//
// Ports:
//   Clk, Reset              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake, cmd_A/cmd_B/cmd_Sel payload
//   ula_A/ula_B/ula_Sel     registered operands and op code to the ULA
//   ula_start               one-cycle start pulse to the ULA
//   ula_SS/ula_S            saturated / raw ULA result
//   ula_Soma_Cout/C7        adder carry out / carry into bit 7
//   ula_Sub_Bout/B7         subtractor borrow out / borrow into bit 7
//   ula_multi_sat           multiplier saturation
//   ula_pronto              ULA result ready
//   ula_res_div_res         division remainder
//   res_valid/res_ready     result handshake, res_data/res_rem payload
//   flag_z/c/v/n/e          zero, carry/borrow, overflow, negative, error
//   busy                    high whenever not idle

module ula_sequenciador #(
    parameter int MULT_TIMEOUT = 16,
    parameter int CNT_W        = 5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_A,
    input  logic [7:0] cmd_B,
    input  logic [2:0] cmd_Sel,
    output logic [7:0] ula_A,
    output logic [7:0] ula_B,
    output logic [2:0] ula_Sel,
    output logic       ula_start,
    input  logic [7:0] ula_SS,
    input  logic [7:0] ula_S,
    input  logic       ula_Soma_Cout,
    input  logic       ula_Soma_C7,
    input  logic       ula_Sub_Bout,
    input  logic       ula_Sub_B7,
    input  logic       ula_multi_sat,
    input  logic       ula_pronto,
    input  logic [7:0] ula_res_div_res,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [7:0] res_rem,
    output logic       flag_z,
    output logic       flag_c,
    output logic       flag_v,
    output logic       flag_n,
    output logic       flag_e,
    output logic       busy
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    // Last WAIT count value: the edge at which the wait gives up.
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(MULT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_ula_A;
    logic [7:0]       r_ula_B;
    logic [2:0]       r_ula_Sel;
    logic             r_start;
    logic             r_cmd_ready;
    logic             r_busy;
    logic             r_res_valid;
    logic [7:0]       r_res_data;
    logic [7:0]       r_res_rem;
    logic             r_flag_z;
    logic             r_flag_c;
    logic             r_flag_v;
    logic             r_flag_n;
    logic             r_flag_e;

    logic             w_is_div;
    logic             w_div0;
    logic             w_pronto_ok;
    logic             w_timeout;
    logic [7:0]       w_cap_data;
    logic [7:0]       w_cap_rem;
    logic             w_cap_c;
    logic             w_cap_v;

    // The result is always taken from the saturated output; the raw result
    // is part of the ULA interface but carries nothing needed here.
    logic             w_unused_raw;
    assign w_unused_raw = ^ula_S;

    assign w_is_div   = (r_ula_Sel == OP_DIV);
    assign w_div0     = w_is_div && (r_ula_B == 8'd0);
    assign w_cap_data = w_div0 ? 8'd0 : ula_SS;
    assign w_cap_rem  = (w_is_div && !w_div0) ? ula_res_div_res : 8'd0;

    // The multiplier's ready line may still be high from the previous op in
    // the first WAIT cycle, so it is only trusted from the second cycle on.
    assign w_pronto_ok = ula_pronto && ((r_ula_Sel != OP_MUL) || (r_cnt != '0));
    assign w_timeout   = (r_cnt == LP_CNT_LAST);

    always_comb begin
        w_cap_c = 1'b0;
        w_cap_v = 1'b0;
        case (r_ula_Sel)
            OP_ADD: begin
                w_cap_c = ula_Soma_Cout;
                w_cap_v = ula_Soma_Cout ^ ula_Soma_C7;
            end
            OP_SUB: begin
                w_cap_c = ula_Sub_Bout;
                w_cap_v = ula_Sub_Bout ^ ula_Sub_B7;
            end
            OP_MUL: begin
                w_cap_v = ula_multi_sat;
            end
            default: begin
                w_cap_c = 1'b0;
                w_cap_v = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ula_A     <= 8'd0;
            r_ula_B     <= 8'd0;
            r_ula_Sel   <= 3'd0;
            r_start     <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= 8'd0;
            r_res_rem   <= 8'd0;
            r_flag_z    <= 1'b0;
            r_flag_c    <= 1'b0;
            r_flag_v    <= 1'b0;
            r_flag_n    <= 1'b0;
            r_flag_e    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_ula_A     <= cmd_A;
                        r_ula_B     <= cmd_B;
                        r_ula_Sel   <= cmd_Sel;
                        r_start     <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_start <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_pronto_ok) begin
                        r_res_data  <= w_cap_data;
                        r_res_rem   <= w_cap_rem;
                        r_flag_z    <= (w_cap_data == 8'd0);
                        r_flag_n    <= w_cap_data[7];
                        r_flag_c    <= w_div0 ? 1'b0 : w_cap_c;
                        r_flag_v    <= w_div0 ? 1'b0 : w_cap_v;
                        r_flag_e    <= w_div0;
                        r_res_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_timeout) begin
                        r_res_data  <= 8'd0;
                        r_res_rem   <= 8'd0;
                        r_flag_z    <= 1'b0;
                        r_flag_n    <= 1'b0;
                        r_flag_c    <= 1'b0;
                        r_flag_v    <= 1'b0;
                        r_flag_e    <= 1'b1;
                        r_res_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign ula_A     = r_ula_A;
    assign ula_B     = r_ula_B;
    assign ula_Sel   = r_ula_Sel;
    assign ula_start = r_start;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_rem   = r_res_rem;
    assign flag_z    = r_flag_z;
    assign flag_c    = r_flag_c;
    assign flag_v    = r_flag_v;
    assign flag_n    = r_flag_n;
    assign flag_e    = r_flag_e;

endmodule

// File: tb/tb_ula_sequenciador.sv
// tb/tb_ula_sequenciador.sv - scoreboard bench for ula_sequenciador with a behavioural ULA stub

module tb_ula_sequenciador;

    localparam int TIMEOUT = 16;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_A = 8'd0;
    logic [7:0] cmd_B = 8'd0;
    logic [2:0] cmd_Sel = 3'd0;
    logic [7:0] ula_A, ula_B;
    logic [2:0] ula_Sel;
    logic       ula_start;
    logic [7:0] ula_SS, ula_S;
    logic       ula_Soma_Cout, ula_Soma_C7, ula_Sub_Bout, ula_Sub_B7, ula_multi_sat;
    logic       ula_pronto;
    logic [7:0] ula_res_div_res;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data, res_rem;
    logic       flag_z, flag_c, flag_v, flag_n, flag_e;
    logic       busy;

    ula_sequenciador #(.MULT_TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .Clk(Clk), .Reset(Reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_Sel(cmd_Sel),
        .ula_A(ula_A), .ula_B(ula_B), .ula_Sel(ula_Sel), .ula_start(ula_start),
        .ula_SS(ula_SS), .ula_S(ula_S),
        .ula_Soma_Cout(ula_Soma_Cout), .ula_Soma_C7(ula_Soma_C7),
        .ula_Sub_Bout(ula_Sub_Bout), .ula_Sub_B7(ula_Sub_B7),
        .ula_multi_sat(ula_multi_sat), .ula_pronto(ula_pronto),
        .ula_res_div_res(ula_res_div_res),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_rem(res_rem),
        .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .flag_n(flag_n), .flag_e(flag_e),
        .busy(busy)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // ULA stub: combinational bit-level model of the arithmetic unit
    logic [8:0]  w_s9;
    logic [7:0]  w_lo;
    logic [15:0] w_p;
    always_comb begin
        w_s9 = {1'b0, ula_A} + {1'b0, ula_B};
        w_lo = {1'b0, ula_A[6:0]} + {1'b0, ula_B[6:0]};
        w_p  = {8'd0, ula_A} * {8'd0, ula_B};
        ula_Soma_Cout   = w_s9[8];
        ula_Soma_C7     = w_lo[7];
        ula_Sub_Bout    = (ula_A < ula_B);
        ula_Sub_B7      = (ula_A[6:0] < ula_B[6:0]);
        ula_multi_sat   = (w_p > 16'd255);
        ula_res_div_res = 8'd0;
        ula_S           = 8'd0;
        ula_SS          = 8'd0;
        case (ula_Sel)
            3'd0: begin ula_S = w_s9[7:0]; ula_SS = w_s9[8] ? 8'd0 : w_s9[7:0]; end
            3'd1: begin ula_S = ula_A - ula_B; ula_SS = (ula_A < ula_B) ? 8'd0 : ula_A - ula_B; end
            3'd2: begin ula_S = w_p[7:0]; ula_SS = (w_p > 16'd255) ? 8'hFF : w_p[7:0]; end
            3'd3: begin
                if (ula_B != 8'd0) begin
                    ula_S = ula_A / ula_B;
                    ula_res_div_res = ula_A % ula_B;
                end else begin
                    ula_S = 8'hFF;
                    ula_res_div_res = ula_A;
                end
                ula_SS = ula_S;
            end
            3'd4: begin ula_S = ula_A & ula_B; ula_SS = ula_S; end
            3'd5: begin ula_S = ula_A | ula_B; ula_SS = ula_S; end
            3'd6: begin ula_S = ula_A ^ ula_B; ula_SS = ula_S; end
            default: begin ula_S = ~ula_A; ula_SS = ula_S; end
        endcase
    end

    // Ready line: first WAIT cycle shows pr_hold, later cycle k shows (k-1 >= pr_dly)
    int tb_k = 1000;
    bit pr_hold = 1'b0;
    int pr_dly = 0;
    always @(posedge Clk) begin
        if (ula_start) tb_k <= 0;
        else if (tb_k < 1000) tb_k <= tb_k + 1;
    end
    assign ula_pronto = (tb_k == 0) ? pr_hold : ((tb_k - 1) >= pr_dly);

    typedef struct {
        logic [7:0] data;
        logic [7:0] rem;
        logic       z, c, v, n, e;
        int         lat;
        int         bp;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_fail = 0;
    int n_issued = 0;
    int n_start_cycles = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic exp_t ref_model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] sel, input bit h, input int dly);
        exp_t x;
        int k, sa, sbv, r;
        x = '{default: 0};
        if (sel == 3'd2) k = (dly <= TIMEOUT - 2) ? dly + 1 : -1;
        else if (h) k = 0;
        else k = (dly <= TIMEOUT - 2) ? dly + 1 : -1;
        if (k < 0) begin
            x.e = 1'b1;
            x.lat = 2 + TIMEOUT - 1;
            return x;
        end
        x.lat = 2 + k;
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        case (sel)
            3'd0: begin
                r = int'(a) + int'(b);
                x.c = (r > 255);
                x.data = x.c ? 8'd0 : r[7:0];
                x.v = ((sa + sbv) > 127) || ((sa + sbv) < -128);
            end
            3'd1: begin
                r = int'(a) - int'(b);
                x.c = (r < 0);
                x.data = x.c ? 8'd0 : r[7:0];
                x.v = ((sa - sbv) > 127) || ((sa - sbv) < -128);
            end
            3'd2: begin
                r = int'(a) * int'(b);
                x.v = (r > 255);
                x.data = x.v ? 8'hFF : r[7:0];
            end
            3'd3: begin
                if (b == 8'd0) x.e = 1'b1;
                else begin
                    x.data = a / b;
                    x.rem  = a % b;
                end
            end
            3'd4: x.data = a & b;
            3'd5: x.data = a | b;
            3'd6: x.data = a ^ b;
            default: x.data = ~a;
        endcase
        x.z = (x.data == 8'd0);
        x.n = x.data[7];
        return x;
    endfunction

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s,
                         input bit h, input int dly, input int bp);
        exp_t x;
        int guard = 0;
        x = ref_model(a, b, s, h, dly);
        x.bp = bp;
        @(negedge Clk);
        while (!cmd_ready && guard < 300) begin
            // stray commands while busy must be dropped, never queued
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_A = 8'($urandom);
            cmd_B = 8'($urandom);
            cmd_Sel = 3'($urandom);
            @(negedge Clk);
            guard++;
        end
        if (!cmd_ready) begin
            chk("issue_wait_cmd_ready", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
        end else begin
            pr_hold = h;
            pr_dly = dly;
            cmd_A = a;
            cmd_B = b;
            cmd_Sel = s;
            cmd_valid = 1'b1;
            x.acc = cyc + 1;
            sb.push_back(x);
            n_issued++;
            @(negedge Clk);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int g = 0;
        while (sb.size() != 0 && g < 3000) begin
            @(negedge Clk);
            g++;
        end
        chk("drain_scoreboard", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge Clk) if (ula_start) n_start_cycles++;

    // Monitor: drives res_ready, checks latency, stability and the popped result
    initial begin
        bit seen;
        int stall;
        logic [7:0] s_data, s_rem;
        logic [4:0] s_flags;
        exp_t x;
        seen = 1'b0;
        stall = 0;
        res_ready = 1'b0;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                seen = 1'b0;
                stall = 0;
                res_ready = 1'b0;
            end else if (res_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'(res_valid), 32'd0);
                    res_ready = 1'b1;
                end else begin
                    x = sb[0];
                    if (!seen) begin
                        seen = 1'b1;
                        stall = 0;
                        chk("latency", 32'(cyc - x.acc), 32'(x.lat));
                        s_data = res_data;
                        s_rem = res_rem;
                        s_flags = {flag_z, flag_c, flag_v, flag_n, flag_e};
                    end else begin
                        chk("hold_data", {16'd0, res_data, res_rem}, {16'd0, s_data, s_rem});
                        chk("hold_flags", 32'({flag_z, flag_c, flag_v, flag_n, flag_e}), 32'(s_flags));
                    end
                    if (stall < x.bp) begin
                        stall++;
                        res_ready = 1'b0;
                        chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
                        chk("bp_busy", 32'(busy), 32'd1);
                    end else begin
                        res_ready = ($urandom_range(0, 2) != 0);
                    end
                    if (res_ready) begin
                        chk("res_data", 32'(res_data), 32'(x.data));
                        chk("res_rem", 32'(res_rem), 32'(x.rem));
                        chk("flags_zcvne", 32'({flag_z, flag_c, flag_v, flag_n, flag_e}),
                            32'({x.z, x.c, x.v, x.n, x.e}));
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end else begin
                res_ready = $urandom_range(0, 1);
            end
        end
    end

    initial begin
        logic [7:0] a, b;
        logic [2:0] s;
        bit h;
        int d;
        repeat (3) @(negedge Clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outs", {ula_A, ula_B, 5'd0, ula_Sel, 6'd0, ula_start, res_valid},
            32'd0);
        chk("rst_res", {res_data, res_rem, 11'd0, flag_z, flag_c, flag_v, flag_n, flag_e}, 32'd0);
        Reset = 1'b1;

        issue(8'd200, 8'd100, 3'd0, 1'b1, 0, 0);
        issue(8'd5,   8'd9,   3'd1, 1'b1, 0, 0);
        issue(8'd9,   8'd5,   3'd1, 1'b1, 0, 0);
        issue(8'd12,  8'd10,  3'd2, 1'b1, 8, 0);
        issue(8'd12,  8'd10,  3'd2, 1'b0, 100, 0);
        issue(8'd23,  8'd5,   3'd3, 1'b1, 0, 0);
        issue(8'd23,  8'd0,   3'd3, 1'b1, 0, 10);
        issue(8'd100, 8'd100, 3'd0, 1'b0, 3, 0);

        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            s = 3'($urandom);
            h = $urandom_range(0, 1);
            d = (s == 3'd2) ? $urandom_range(0, 20) : $urandom_range(0, 14);
            issue(a, b, s, h, d, $urandom_range(0, 3));
        end
        wait_drain();

        // abandon a multiply by reset while it is waiting
        issue(8'd7, 8'd9, 3'd2, 1'b0, 100, 0);
        repeat (4) @(negedge Clk);
        chk("mid_busy", 32'(busy), 32'd1);
        #2 Reset = 1'b0;
        #1;
        chk("mid_rst_ctl", 32'({busy, ula_start, res_valid}), 32'd0);
        chk("mid_rst_ops", {ula_A, ula_B, 5'd0, ula_Sel, 8'd0}, 32'd0);
        chk("mid_rst_res", {res_data, res_rem, 11'd0, flag_z, flag_c, flag_v, flag_n, flag_e}, 32'd0);
        sb.delete();
        @(negedge Clk);
        #2 Reset = 1'b1;
        @(negedge Clk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_valid", 32'(res_valid), 32'd0);

        issue(8'd3, 8'd4, 3'd4, 1'b1, 0, 0);
        wait_drain();
        repeat (2) @(negedge Clk);
        chk("start_pulse_cycles", 32'(n_start_cycles), 32'(n_issued));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
